dev4_buf_ctrl: RTL and testbench

- Sequencer and arbiter for one subaddress data buffer: a 32 x 16 simple dual-port RAM with a registered read, running on a single clock.
- Moves 1553 receive words from the decoder into the buffer and feeds transmit words to the encoder.
- Gives the host CPU read/write access whenever no bus message is in progress.
- Sits between the command decoder, the Manchester codec word interfaces and the host register bus.

---
 rtl/mkio_pkg.sv | 28 ++
 rtl/mkio_word_timer.sv | 35 +++
 rtl/dev4_buf_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dev4_buf_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// Shared definitions for the subaddress buffer controller.
//   state_t         : controller sequencer states
//   timer_width()   : counter width needed to reach a given cycle limit
//   wc_to_target()  : 1553 word-count field to word total (0 means 2**aw)
//   TIMER_W         : timer width for the default 1200-cycle inter-word limit
package mkio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_FETCH,
    ST_TX_LOAD,
    ST_TX_SEND,
    ST_HOST_RD
  } state_t;

  function automatic int unsigned timer_width(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

  function automatic int unsigned wc_to_target(input int unsigned wc, input int unsigned aw);
    return (wc == 0) ? (32'd1 << aw) : wc;
  endfunction

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1200;
  localparam int unsigned TIMER_W = timer_width(TIMEOUT_CYC_DEFAULT);

endpackage

// File: rtl/mkio_word_timer.sv
// Inter-word timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart from zero (word event or not in a timed state)
//   en         : count this cycle
//   expire     : this idle cycle is the LIMIT-th since the last clear
module mkio_word_timer
  import mkio_pkg::*;
#(
  parameter int unsigned LIMIT = 1200,
  parameter int unsigned W     = timer_width(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // Fires on the cycle whose edge would bring the count to LIMIT, so the
  // abort lands exactly LIMIT edges after the last word.
  assign expire = en && !clr && (count == W'(LIMIT - 1));

endmodule

// File: rtl/dev4_buf_ctrl.sv
// Sequencer/arbiter for one subaddress data buffer (32 x 16 simple dual-port
// RAM, registered read, single clock).
//   cmd_*      : command from the decoder (valid pulse, T/R bit, word count)
//   rx_*       : decoded receive words
//   tx_*       : transmit words to the encoder (valid/ready)
//   host_*     : host CPU buffer access, served only while no message runs
//   msg_*      : message completion/abort pulses and word count
//   ram_*      : buffer RAM ports; ram_q is valid 1 cycle after ram_rdaddress
module dev4_buf_ctrl
  import mkio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned TIMEOUT_CYC = 1200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic                  cmd_tr,
  input  logic [ADDR_WIDTH-1:0] cmd_wc,
  output logic                  cmd_busy,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_err,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  msg_done,
  output logic                  msg_err,
  output logic [ADDR_WIDTH:0]   msg_cnt,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned TW = timer_width(TIMEOUT_CYC);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   target;

  // Command that arrived while a host read was completing.
  logic                  pend_valid;
  logic                  pend_tr;
  logic [ADDR_WIDTH-1:0] pend_wc;

  logic                  busy_state;
  logic                  supersede;
  logic                  start_go;
  logic                  start_tr;
  logic [ADDR_WIDTH-1:0] start_wc;
  logic                  word_evt;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic                  last_word;
  logic                  host_go;
  logic                  tmr_en;
  logic                  tmr_clr;
  logic                  tmr_expire;

  always_comb begin
    busy_state = (state == ST_RX) || (state == ST_TX_FETCH) ||
                 (state == ST_TX_LOAD) || (state == ST_TX_SEND);
    supersede  = cmd_valid && busy_state;
    start_go   = supersede || ((state == ST_IDLE) && (cmd_valid || pend_valid));
    start_tr   = cmd_valid ? cmd_tr : pend_tr;
    start_wc   = cmd_valid ? cmd_wc : pend_wc;
    word_evt   = ((state == ST_RX) && rx_valid && !rx_err) ||
                 ((state == ST_TX_SEND) && tx_valid && tx_ready);
    cnt_next   = msg_cnt + (ADDR_WIDTH + 1)'(1);
    last_word  = (cnt_next == target);
    // host_ack is still high on the cycle after completion while the host
    // has not yet seen it and dropped host_req; do not re-accept then.
    host_go    = host_req && !host_ack;
    tmr_en     = (state == ST_RX) || (state == ST_TX_SEND);
    tmr_clr    = word_evt || !tmr_en;
  end

  // Read address is combinational so the registered RAM output lines up with
  // the following state (HOST_RD or TX_LOAD).
  always_comb begin
    ram_rdaddress = '0;
    case (state)
      ST_IDLE:     ram_rdaddress = host_addr;
      ST_TX_FETCH: ram_rdaddress = ptr;
      default:     ram_rdaddress = '0;
    endcase
  end

  mkio_word_timer #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      target        <= '0;
      pend_valid    <= 1'b0;
      pend_tr       <= 1'b0;
      pend_wc       <= '0;
      cmd_busy      <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      host_ack      <= 1'b0;
      host_rdata    <= '0;
      msg_done      <= 1'b0;
      msg_err       <= 1'b0;
      msg_cnt       <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
    end else begin
      ram_wren <= 1'b0;
      host_ack <= 1'b0;
      msg_done <= 1'b0;
      msg_err  <= 1'b0;

      // Every busy-state branch stands aside when cmd_valid is high; the
      // start block below then owns the transition.
      case (state)
        ST_IDLE: begin
          if (!(cmd_valid || pend_valid) && host_go) begin
            if (host_we) begin
              ram_wren      <= 1'b1;
              ram_wraddress <= host_addr;
              ram_data      <= host_wdata;
              host_ack      <= 1'b1;
            end else begin
              state <= ST_HOST_RD;
            end
          end
        end

        ST_HOST_RD: begin
          host_rdata <= ram_q;
          host_ack   <= 1'b1;
          state      <= ST_IDLE;
          if (cmd_valid) begin
            pend_valid <= 1'b1;
            pend_tr    <= cmd_tr;
            pend_wc    <= cmd_wc;
          end
        end

        ST_RX: begin
          if (!cmd_valid) begin
            if (rx_valid && rx_err) begin
              msg_err  <= 1'b1;
              cmd_busy <= 1'b0;
              state    <= ST_IDLE;
            end else if (rx_valid) begin
              ram_wren      <= 1'b1;
              ram_wraddress <= ptr;
              ram_data      <= rx_data;
              ptr           <= ptr + ADDR_WIDTH'(1);
              msg_cnt       <= cnt_next;
              if (last_word) begin
                msg_done <= 1'b1;
                cmd_busy <= 1'b0;
                state    <= ST_IDLE;
              end
            end else if (tmr_expire) begin
              msg_err  <= 1'b1;
              cmd_busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end

        ST_TX_FETCH: begin
          if (!cmd_valid) begin
            state <= ST_TX_LOAD;
          end
        end

        ST_TX_LOAD: begin
          if (!cmd_valid) begin
            tx_data  <= ram_q;
            tx_valid <= 1'b1;
            state    <= ST_TX_SEND;
          end
        end

        ST_TX_SEND: begin
          if (!cmd_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              ptr      <= ptr + ADDR_WIDTH'(1);
              msg_cnt  <= cnt_next;
              if (last_word) begin
                msg_done <= 1'b1;
                cmd_busy <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                state <= ST_TX_FETCH;
              end
            end else if (tmr_expire) begin
              tx_valid <= 1'b0;
              msg_err  <= 1'b1;
              cmd_busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // New command: fresh or pending from IDLE, or superseding a live one.
      if (start_go) begin
        state      <= start_tr ? ST_TX_FETCH : ST_RX;
        ptr        <= '0;
        msg_cnt    <= '0;
        target     <= (ADDR_WIDTH + 1)'(wc_to_target(32'(start_wc), ADDR_WIDTH));
        cmd_busy   <= 1'b1;
        tx_valid   <= 1'b0;
        pend_valid <= 1'b0;
        msg_err    <= supersede;
      end
    end
  end

endmodule

// File: tb/tb_dev4_buf_ctrl.sv
module tb_dev4_buf_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 1200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_tr;
  logic [AW-1:0] cmd_wc;
  logic          cmd_busy;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_err;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          msg_done;
  logic          msg_err;
  logic [AW:0]   msg_cnt;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddress;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [0:31];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  dev4_buf_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_tr        (cmd_tr),
    .cmd_wc        (cmd_wc),
    .cmd_busy      (cmd_busy),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_err        (rx_err),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_ack      (host_ack),
    .host_rdata    (host_rdata),
    .msg_done      (msg_done),
    .msg_err       (msg_err),
    .msg_cnt       (msg_cnt),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_rdaddress (ram_rdaddress),
    .ram_q         (ram_q)
  );

  always #5 clk = ~clk;

  // Buffer RAM: simple dual port, registered read.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  always @(posedge clk) begin
    if (msg_done) done_cnt <= done_cnt + 1;
    if (msg_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    tick();
    while (!host_ack && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(host_ack), 32'd1);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    wait_ack("host_write_ack");
    host_req = 1'b0; host_we = 1'b0;
    tick();
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    wait_ack("host_read_ack");
    d = host_rdata;
    host_req = 1'b0;
    tick();
  endtask

  task automatic start_cmd(input logic tr, input logic [AW-1:0] wc);
    cmd_valid = 1'b1; cmd_tr = tr; cmd_wc = wc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n;
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_valid), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int            d0;
    int            e0;
    int            n;
    logic          early_ack;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_tr = 1'b0; cmd_wc = '0;
    rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
    tx_ready = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(cmd_busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_msg_cnt", 32'(msg_cnt), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_done_err", 32'({msg_done, msg_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Host write 0xA5A5 to addr 3: ack one cycle after the request
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd3; host_wdata = 16'hA5A5;
    tick();
    chk("hw_ack", 32'(host_ack), 32'd1);
    chk("hw_wren", 32'(ram_wren), 32'd1);
    chk("hw_wraddr", 32'(ram_wraddress), 32'd3);
    chk("hw_wdata", 32'(ram_data), 32'hA5A5);
    host_req = 1'b0; host_we = 1'b0;
    tick();
    chk("hw_ack_pulse", 32'(host_ack), 32'd0);
    chk("hw_wren_pulse", 32'(ram_wren), 32'd0);

    // Host read of addr 3: ack two cycles after acceptance
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
    tick();
    chk("hr_ack_early", 32'(host_ack), 32'd0);
    tick();
    chk("hr_ack", 32'(host_ack), 32'd1);
    chk("hr_rdata", 32'(host_rdata), 32'hA5A5);
    host_req = 1'b0;
    tick();
    chk("hr_ack_pulse", 32'(host_ack), 32'd0);

    // Receive wc=4
    d0 = done_cnt;
    start_cmd(1'b0, 5'd4);
    chk("rx4_busy", 32'(cmd_busy), 32'd1);
    chk("rx4_cnt0", 32'(msg_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 16'(16'h1111 * (i + 1));
      tick();
      rx_valid = 1'b0;
      chk("rx4_wren", 32'(ram_wren), 32'd1);
      chk("rx4_wraddr", 32'(ram_wraddress), 32'(i));
      chk("rx4_wdata", 32'(ram_data), 32'(16'h1111 * (i + 1)));
      chk("rx4_cnt", 32'(msg_cnt), 32'(i + 1));
      chk("rx4_done", 32'(msg_done), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("rx4_busy_end", 32'(cmd_busy), 32'd0);
    tick();
    chk("rx4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("rx4_mem0", 32'(mem[0]), 32'h1111);
    chk("rx4_mem3", 32'(mem[3]), 32'h4444);
    host_read(5'd2, rd);
    chk("rx4_host_rd2", 32'(rd), 32'h3333);

    // Transmit wc=0 (32 words), buffer preloaded addr=data
    for (int i = 0; i < 32; i++) host_write(5'(i), 16'(i));
    d0 = done_cnt;
    start_cmd(1'b1, 5'd0);
    chk("tx32_busy", 32'(cmd_busy), 32'd1);
    for (int k = 0; k < 32; k++) begin
      wait_tx("tx32_valid_wait");
      chk("tx32_data", 32'(tx_data), 32'(k));
      if (k == 10) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("tx32_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx32_hold_data", 32'(tx_data), 32'd10);
        end
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("tx32_valid_drop", 32'(tx_valid), 32'd0);
      chk("tx32_cnt", 32'(msg_cnt), 32'(k + 1));
      chk("tx32_done", 32'(msg_done), (k == 31) ? 32'd1 : 32'd0);
    end
    chk("tx32_busy_end", 32'(cmd_busy), 32'd0);
    tick();
    chk("tx32_done_once", 32'(done_cnt - d0), 32'd1);

    // Receive wc=3 with rx_err on the second word
    d0 = done_cnt;
    start_cmd(1'b0, 5'd3);
    rx_valid = 1'b1; rx_data = 16'hB001;
    tick();
    rx_valid = 1'b0;
    chk("rxe_w0_wren", 32'(ram_wren), 32'd1);
    rx_valid = 1'b1; rx_err = 1'b1; rx_data = 16'hB002;
    tick();
    rx_valid = 1'b0; rx_err = 1'b0;
    chk("rxe_err", 32'(msg_err), 32'd1);
    chk("rxe_busy", 32'(cmd_busy), 32'd0);
    chk("rxe_no_wren", 32'(ram_wren), 32'd0);
    tick();
    chk("rxe_err_pulse", 32'(msg_err), 32'd0);
    chk("rxe_mem0", 32'(mem[0]), 32'hB001);
    chk("rxe_mem1", 32'(mem[1]), 32'h0001);
    chk("rxe_no_done", 32'(done_cnt - d0), 32'd0);

    // Receive wc=2, one word, then silence; host read pending meanwhile
    start_cmd(1'b0, 5'd2);
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd0;
    rx_valid = 1'b1; rx_data = 16'hC001;
    tick();
    rx_valid = 1'b0;
    chk("to_wren", 32'(ram_wren), 32'd1);
    early_ack = 1'b0;
    n = 0;
    for (int i = 1; i <= 2 * TO; i++) begin
      tick();
      if (host_ack) early_ack = 1'b1;
      if (msg_err) begin
        n = i;
        break;
      end
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_busy", 32'(cmd_busy), 32'd0);
    chk("to_no_early_ack", 32'(early_ack), 32'd0);
    wait_ack("to_host_ack");
    chk("to_host_rdata", 32'(host_rdata), 32'hC001);
    host_req = 1'b0;
    tick();

    // Superseding command
    d0 = done_cnt;
    e0 = err_cnt;
    start_cmd(1'b0, 5'd4);
    rx_valid = 1'b1; rx_data = 16'hE001;
    tick();
    rx_valid = 1'b0;
    chk("sup_cnt1", 32'(msg_cnt), 32'd1);
    start_cmd(1'b0, 5'd2);
    chk("sup_err", 32'(msg_err), 32'd1);
    chk("sup_busy", 32'(cmd_busy), 32'd1);
    chk("sup_cnt0", 32'(msg_cnt), 32'd0);
    rx_valid = 1'b1; rx_data = 16'hE101;
    tick();
    rx_data = 16'hE102;
    tick();
    rx_valid = 1'b0;
    chk("sup_done", 32'(msg_done), 32'd1);
    chk("sup_wraddr", 32'(ram_wraddress), 32'd1);
    tick();
    chk("sup_done_once", 32'(done_cnt - d0), 32'd1);
    chk("sup_err_once", 32'(err_cnt - e0), 32'd1);

    // Same-cycle cmd_valid and host_req in IDLE: command wins
    cmd_valid = 1'b1; cmd_tr = 1'b0; cmd_wc = 5'd1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7; host_wdata = 16'h7777;
    tick();
    cmd_valid = 1'b0;
    chk("pri_busy", 32'(cmd_busy), 32'd1);
    chk("pri_no_ack", 32'(host_ack), 32'd0);
    chk("pri_no_wren", 32'(ram_wren), 32'd0);
    rx_valid = 1'b1; rx_data = 16'hD001;
    tick();
    rx_valid = 1'b0;
    chk("pri_done", 32'(msg_done), 32'd1);
    chk("pri_rx_wraddr", 32'(ram_wraddress), 32'd0);
    tick();
    chk("pri_host_ack", 32'(host_ack), 32'd1);
    chk("pri_host_wraddr", 32'(ram_wraddress), 32'd7);
    chk("pri_host_wdata", 32'(ram_data), 32'h7777);
    host_req = 1'b0; host_we = 1'b0;
    tick();

    // Reset asserted mid-transmit
    start_cmd(1'b1, 5'd4);
    wait_tx("rst_tx_wait");
    chk("rst_tx_busy_pre", 32'(cmd_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(cmd_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid_cnt", 32'(msg_cnt), 32'd0);
    chk("rst_mid_still_idle", 32'(tx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
